// File: rtl/stacking_sub_chunk_seq_pkg.sv
// stacking_sub_chunk_seq_pkg: shared sizing, FSM states and sub-chunk config for the sub-chunk sequencer
package stacking_pkg;
  localparam int RD_DAT_CYC_NUM = 16;
  localparam int PREFIX_SUM_SIZE = 32;
  localparam int OUTPUT_BUF_NUM = 64;
  localparam int AW = $clog2(RD_DAT_CYC_NUM);
  localparam int SW = $clog2(PREFIX_SUM_SIZE);
  localparam int BW = $clog2(OUTPUT_BUF_NUM);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [AW-1:0] fil_first;
    logic [AW-1:0] fil_last;
    logic [AW-1:0] ifm_first;
    logic [AW-1:0] ifm_next;
    logic [SW-1:0] shift;
    logic [BW-1:0] acc_sel;
  } sub_chunk_cfg_t;
endpackage

// File: rtl/stacking_sub_chunk_seq_rd_addr_gen.sv
// stacking_rd_addr_gen: beat counter and wrapping fil/ifm sparsemap addresses with first/last flags
module stacking_rd_addr_gen
  import stacking_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load,
  input  logic          adv,
  input  logic [AW-1:0] fil_first,
  input  logic [AW-1:0] fil_last,
  input  logic [AW-1:0] ifm_first,
  input  logic [AW-1:0] ifm_next,
  output logic [AW-1:0] fil_addr,
  output logic [AW-1:0] ifm_addr,
  output logic          first,
  output logic          last
);
  logic [AW:0]   cnt;
  logic [AW-1:0] ifm_off;
  logic [AW:0]   n_m1;
  always_ff @(posedge clk_i) begin
    if (rst_i || load) begin
      cnt     <= '0;
      ifm_off <= '0;
    end else if (adv) begin
      cnt     <= cnt + 1'b1;
      ifm_off <= ifm_off + ifm_next;
    end
  end
  // addresses are base + offset in AW bits, so the buffer wrap falls out of the width
  assign n_m1     = {1'b0, fil_last - fil_first};
  assign fil_addr = fil_first + cnt[AW-1:0];
  assign ifm_addr = ifm_first + ifm_off;
  assign first    = cnt == '0;
  assign last     = cnt == n_m1;
endmodule

// File: rtl/stacking_sub_chunk_seq.sv
// stacking_sub_chunk_seq: latches a sub-chunk read window, issues sparsemap read beats, drains, pulses end.
// Optional STACKING_SUB_CHUNK_ERR_CHK_EN enables the sticky protocol error flag on err_o.
module stacking_sub_chunk_seq
  import stacking_pkg::*;
#(
  parameter int DRAIN_CYC = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          sub_chunk_start_i,
  input  logic [AW-1:0] rd_fil_sparsemap_first_i,
  input  logic [AW-1:0] rd_fil_sparsemap_last_i,
  input  logic [AW-1:0] rd_ifm_sparsemap_first_i,
  input  logic [AW-1:0] rd_ifm_sparsemap_next_i,
  input  logic [SW-1:0] sparsemap_shift_left_i,
  input  logic [BW-1:0] acc_buf_sel_i,
  output logic          rd_req_o,
  input  logic          rd_gnt_i,
  output logic [AW-1:0] rd_fil_addr_o,
  output logic [AW-1:0] rd_ifm_addr_o,
  output logic [SW-1:0] rd_shift_o,
  output logic          rd_first_o,
  output logic          rd_last_o,
  output logic [BW-1:0] acc_buf_sel_o,
  output logic          busy_o,
  output logic          sub_chunk_end_o,
  output logic          err_o
);
  localparam int DW = DRAIN_CYC > 1 ? $clog2(DRAIN_CYC) : 1;
  state_t         state, state_nx;
  logic [DW-1:0]  drain_cnt, drain_cnt_nx;
  sub_chunk_cfg_t cfg_q;
  logic           load, adv, first, last;
  logic [AW-1:0]  fil_ptr, ifm_ptr;
  assign load = (state == IDLE) && sub_chunk_start_i;
  assign adv  = (state == ISSUE) && rd_gnt_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      drain_cnt <= '0;
      cfg_q     <= '0;
    end else begin
      state     <= state_nx;
      drain_cnt <= drain_cnt_nx;
      if (load) cfg_q <= '{rd_fil_sparsemap_first_i, rd_fil_sparsemap_last_i, rd_ifm_sparsemap_first_i,
                           rd_ifm_sparsemap_next_i, sparsemap_shift_left_i, acc_buf_sel_i};
    end
  end
  always_comb begin
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    if (load) state_nx = ISSUE;
    if (adv && last) begin
      state_nx     = DRAIN;
      drain_cnt_nx = DW'(DRAIN_CYC - 1);
    end
    if (state == DRAIN) begin
      state_nx     = drain_cnt == '0 ? DONE : DRAIN;
      drain_cnt_nx = drain_cnt == '0 ? drain_cnt : drain_cnt - 1'b1;
    end
    if (state == DONE) state_nx = IDLE;
  end
  stacking_rd_addr_gen u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load      (load),
    .adv       (adv),
    .fil_first (cfg_q.fil_first),
    .fil_last  (cfg_q.fil_last),
    .ifm_first (cfg_q.ifm_first),
    .ifm_next  (cfg_q.ifm_next),
    .fil_addr  (fil_ptr),
    .ifm_addr  (ifm_ptr),
    .first     (first),
    .last      (last)
  );
  assign rd_req_o        = state == ISSUE;
  assign rd_fil_addr_o   = rd_req_o ? fil_ptr : '0;
  assign rd_ifm_addr_o   = rd_req_o ? ifm_ptr : '0;
  assign rd_first_o      = rd_req_o && first;
  assign rd_last_o       = rd_req_o && last;
  assign rd_shift_o      = cfg_q.shift;
  assign acc_buf_sel_o   = cfg_q.acc_sel;
  assign busy_o          = state != IDLE;
  assign sub_chunk_end_o = state == DONE;
`ifdef STACKING_SUB_CHUNK_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if ((sub_chunk_start_i && busy_o) || (rd_gnt_i && !rd_req_o)) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_stacking_sub_chunk_seq.sv
// tb_stacking_sub_chunk_seq: scoreboard bench; stimulus pushes expected beats/ends, a monitor pops and compares
module tb_stacking_sub_chunk_seq;
  import stacking_pkg::*;
  localparam int DRAIN_CYC = 3;
  localparam int R = RD_DAT_CYC_NUM;
  logic clk = 0, rst_i = 1, start = 0, gnt = 0;
  logic [AW-1:0] fil_first = 0, fil_last = 0, ifm_first = 0, ifm_next = 0;
  logic [SW-1:0] shift = 0;
  logic [BW-1:0] acc = 0;
  logic rd_req_o, rd_first_o, rd_last_o, busy_o, sub_chunk_end_o, err_o;
  logic [AW-1:0] rd_fil_addr_o, rd_ifm_addr_o;
  logic [SW-1:0] rd_shift_o;
  logic [BW-1:0] acc_buf_sel_o;
  typedef struct packed {logic [AW-1:0] fil, ifm; logic first, last; logic [SW-1:0] shift; logic [BW-1:0] acc;} beat_t;
  typedef struct packed {logic [SW-1:0] shift; logic [BW-1:0] acc;} end_t;
  beat_t beat_q[$];
  end_t  end_q[$];
  int checks = 0, errors = 0, cyc = 0, last_gnt = 0, req_cycles = 0, idle_len = 0, gnt_mode = 1;
  logic gnt_man = 0;
  bit err_exp = 0, b2b_mode = 0;

  stacking_sub_chunk_seq #(.DRAIN_CYC(DRAIN_CYC)) dut (
    .clk_i(clk), .rst_i(rst_i), .sub_chunk_start_i(start),
    .rd_fil_sparsemap_first_i(fil_first), .rd_fil_sparsemap_last_i(fil_last),
    .rd_ifm_sparsemap_first_i(ifm_first), .rd_ifm_sparsemap_next_i(ifm_next),
    .sparsemap_shift_left_i(shift), .acc_buf_sel_i(acc),
    .rd_req_o(rd_req_o), .rd_gnt_i(gnt), .rd_fil_addr_o(rd_fil_addr_o), .rd_ifm_addr_o(rd_ifm_addr_o),
    .rd_shift_o(rd_shift_o), .rd_first_o(rd_first_o), .rd_last_o(rd_last_o), .acc_buf_sel_o(acc_buf_sel_o),
    .busy_o(busy_o), .sub_chunk_end_o(sub_chunk_end_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    gnt = gnt_mode == 1 ? 1'b1 : gnt_mode == 2 ? (rd_req_o && $urandom_range(0, 3) != 0) : gnt_man;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit err_want();
`ifdef STACKING_SUB_CHUNK_ERR_CHK_EN
    return err_exp;
`else
    return 1'b0;
`endif
  endfunction

  // monitor: every requested cycle must match the head beat; ends must match head config and drain latency
  always @(negedge clk) begin
    if (!rst_i) begin
      if (rd_req_o) begin
        req_cycles++;
        chk("beat_pending", beat_q.size() > 0, 1);
        if (beat_q.size() > 0) begin
          chk("beat", {rd_fil_addr_o, rd_ifm_addr_o, rd_first_o, rd_last_o, rd_shift_o, acc_buf_sel_o}, beat_q[0]);
          if (gnt) begin
            last_gnt = cyc;
            void'(beat_q.pop_front());
          end
        end
      end
      if (sub_chunk_end_o) begin
        chk("end_pending", end_q.size() > 0, 1);
        if (end_q.size() > 0) chk("end_cfg", {rd_shift_o, acc_buf_sel_o}, end_q.pop_front());
        chk("end_latency", cyc - last_gnt, DRAIN_CYC + 1);
      end
      if (!busy_o) idle_len++;
      else begin
        if (b2b_mode && idle_len > 0) chk("b2b_idle_gap", idle_len, 1);
        idle_len = 0;
      end
    end
  end

  task automatic start_chunk(input logic [AW-1:0] ff, input logic [AW-1:0] fl, input logic [AW-1:0] i0,
                             input logic [AW-1:0] nx, input logic [SW-1:0] sh, input logic [BW-1:0] ac,
                             input bit accept, output int st);
    int f, n;
    @(posedge clk); #1;
    fil_first = ff; fil_last = fl; ifm_first = i0; ifm_next = nx; shift = sh; acc = ac; start = 1;
    st = cyc;
    if (accept) begin
      f = int'(ff);
      n = ((int'(fl) - f + R) % R) + 1;
      for (int i = 0; i < n; i++) begin
        beat_t b;
        b.fil = AW'((f + i) % R);
        b.ifm = AW'((int'(i0) + i * int'(nx)) % R);
        b.first = i == 0;
        b.last = i == n - 1;
        b.shift = sh;
        b.acc = ac;
        beat_q.push_back(b);
      end
      end_q.push_back({sh, ac});
    end
    @(posedge clk); #1;
    start = 0;
    fil_first = AW'($urandom); fil_last = AW'($urandom); ifm_first = AW'($urandom);
    ifm_next = AW'($urandom); shift = SW'($urandom); acc = BW'($urandom);
  endtask

  task automatic wait_end(output int ec);
    int k = 0;
    @(negedge clk);
    while (!sub_chunk_end_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("end_seen", sub_chunk_end_o, 1);
    ec = cyc;
  endtask

  function automatic logic [63:0] all_outs();
    return {rd_req_o, rd_fil_addr_o, rd_ifm_addr_o, rd_shift_o, rd_first_o, rd_last_o,
            acc_buf_sel_o, busy_o, sub_chunk_end_o, err_o};
  endfunction

  initial begin
    int st, ec, nend;
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    // 1: gnt tied high, 3 beats, fixed latency
    start_chunk(2, 4, 5, 3, 5'd9, 6'd17, 1, st);
    wait_end(ec);
    chk("t1_latency", ec - st, 3 + DRAIN_CYC + 1);
    err_exp = 1;
    chk("t1_err", err_o, err_want());
    // 2: filter window wraps past the buffer end
    start_chunk(14, 1, 0, 3, 5'd31, 6'd63, 1, st);
    wait_end(ec);
    chk("t2_drained", beat_q.size(), 0);
    // 3: single beat stalled three cycles
    gnt_mode = 0;
    gnt_man = 0;
    start_chunk(7, 7, 4, 2, 5'd1, 6'd2, 1, st);
    req_cycles = 0;
    repeat (3) @(negedge clk);
    gnt_man = 1;
    wait_end(ec);
    chk("t3_req_cycles", req_cycles, 4);
    gnt_man = 0;
    // 4: start while busy is ignored
    gnt_mode = 1;
    start_chunk(0, 9, 1, 5, 5'd3, 6'd40, 1, st);
    repeat (2) @(posedge clk);
    start_chunk(3, 3, 8, 1, 5'd20, 6'd5, 0, st);
    wait_end(ec);
    repeat (10) @(negedge clk);
    chk("t4_queues", beat_q.size() + end_q.size(), 0);
    chk("t4_err", err_o, err_want());
    // 5: reset during drain aborts with no end pulse
    start_chunk(0, 2, 3, 1, 5'd7, 6'd7, 1, st);
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1;
    gnt_mode = 2;
    beat_q.delete();
    end_q.delete();
    @(posedge clk); #1;
    rst_i = 0;
    err_exp = 0;
    @(negedge clk);
    chk("t5_reset_outs", all_outs(), 0);
    repeat (10) @(negedge clk);
    chk("t5_idle", busy_o, 0);
    start_chunk(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), SW'($urandom), BW'($urandom), 1, st);
    wait_end(ec);
    // 6: eight back-to-back random sub-chunks with random grants
    nend = 0;
    start_chunk(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), SW'($urandom), BW'($urandom), 1, st);
    for (int i = 0; i < 8; i++) begin
      wait_end(ec);
      if (sub_chunk_end_o) nend++;
      b2b_mode = 1;
      if (i < 7)
        start_chunk(AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), SW'($urandom), BW'($urandom), 1, st);
    end
    b2b_mode = 0;
    chk("t6_ends", nend, 8);
    repeat (20) @(negedge clk);
    chk("final_queues", beat_q.size() + end_q.size(), 0);
    chk("final_err", err_o, err_want());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks %0d, errors %0d)", checks, errors);
    $fatal(1);
  end
endmodule
